// File: rtl/ip_bridge_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ip_bridge_if : pipeline/IP handshake bundle for ip_bridge        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ip_bridge_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          IP_write;
    logic          IP_read;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_wdata;
    logic          stall;
    logic          ip_in_valid;
    logic [DW-1:0] ip_in_data;
    logic          ip_in_ready;
    logic          ip_out_valid;
    logic [DW-1:0] ip_out_data;
    logic          ip_out_ready;
    logic [CW-1:0] wcount;
    logic [CW-1:0] rcount;

    modport master (
        output IP_write, IP_read, mem_rdata, ip_in_ready, ip_out_valid, ip_out_data,
        input  mem_wdata, stall, ip_in_valid, ip_in_data, ip_out_ready, wcount, rcount
    );

    modport slave (
        input  IP_write, IP_read, mem_rdata, ip_in_ready, ip_out_valid, ip_out_data,
        output mem_wdata, stall, ip_in_valid, ip_in_data, ip_out_ready, wcount, rcount
    );
endinterface
`default_nettype wire

// File: rtl/ip_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ip_bridge : two DEPTH-entry FIFOs between data memory and an IP  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ip_bridge #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    ip_bridge_if.slave  bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] wmem_q [DEPTH];
    logic [DW-1:0] rmem_q [DEPTH];

    logic [AW-1:0] wwr_ptr_q, wwr_ptr_d, wrd_ptr_q, wrd_ptr_d;
    logic [AW-1:0] rwr_ptr_q, rwr_ptr_d, rrd_ptr_q, rrd_ptr_d;
    logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

    logic lwip, swip;
    logic wfull, wempty, rfull, rempty;
    logic wpush, wpop, rpush, rpop;
    logic out_ready;

    always_comb begin
        lwip      = bus.IP_write & ~bus.IP_read;
        swip      = bus.IP_read & ~bus.IP_write;
        wfull     = (wcnt_q == FULL);
        wempty    = (wcnt_q == '0);
        rfull     = (rcnt_q == FULL);
        rempty    = (rcnt_q == '0);
        out_ready = rst & ~rfull;

        // Full/empty are judged on registered counts only: no bypass paths.
        wpush = lwip & ~wfull;
        wpop  = ~wempty & bus.ip_in_ready;
        rpush = bus.ip_out_valid & out_ready;
        rpop  = swip & ~rempty;

        wwr_ptr_d = wpush ? wwr_ptr_q + AW'(1) : wwr_ptr_q;
        wrd_ptr_d = wpop  ? wrd_ptr_q + AW'(1) : wrd_ptr_q;
        rwr_ptr_d = rpush ? rwr_ptr_q + AW'(1) : rwr_ptr_q;
        rrd_ptr_d = rpop  ? rrd_ptr_q + AW'(1) : rrd_ptr_q;

        wcnt_d = wcnt_q;
        case ({wpush, wpop})
            2'b10:   wcnt_d = wcnt_q + CW'(1);
            2'b01:   wcnt_d = wcnt_q - CW'(1);
            default: wcnt_d = wcnt_q;
        endcase

        rcnt_d = rcnt_q;
        case ({rpush, rpop})
            2'b10:   rcnt_d = rcnt_q + CW'(1);
            2'b01:   rcnt_d = rcnt_q - CW'(1);
            default: rcnt_d = rcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wwr_ptr_q <= '0;
            wrd_ptr_q <= '0;
            rwr_ptr_q <= '0;
            rrd_ptr_q <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            wwr_ptr_q <= wwr_ptr_d;
            wrd_ptr_q <= wrd_ptr_d;
            rwr_ptr_q <= rwr_ptr_d;
            rrd_ptr_q <= rrd_ptr_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wpush) wmem_q[wwr_ptr_q] <= bus.mem_rdata;
        if (rpush) rmem_q[rwr_ptr_q] <= bus.ip_out_data;
    end

    assign bus.stall        = rst & ((lwip & wfull) | (swip & rempty));
    assign bus.mem_wdata    = rpop ? rmem_q[rrd_ptr_q] : '0;
    assign bus.ip_in_valid  = ~wempty;
    assign bus.ip_in_data   = wmem_q[wrd_ptr_q];
    assign bus.ip_out_ready = out_ready;
    assign bus.wcount       = wcnt_q;
    assign bus.rcount       = rcnt_q;
endmodule
`default_nettype wire

// File: tb/tb_ip_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ip_bridge : randomized + directed bench with a queue model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ip_bridge;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ip_bridge_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
    ip_bridge #(.DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] wq[$];
    logic [DW-1:0] rq[$];
    logic          last_rpop;
    logic [DW-1:0] last_rval;

    task automatic set_in(input logic w, input logic r, input logic [DW-1:0] md,
                          input logic inr, input logic outv, input logic [DW-1:0] od);
        bus.IP_write     = w;
        bus.IP_read      = r;
        bus.mem_rdata    = md;
        bus.ip_in_ready  = inr;
        bus.ip_out_valid = outv;
        bus.ip_out_data  = od;
    endtask

    // Queue model: decide transfers from the pre-edge occupancy, clock, then apply.
    task automatic tick();
        logic wpush, wpop, rpush, rpop;
        logic [DW-1:0] wd, rd;
        wpush = bus.IP_write && !bus.IP_read && (wq.size() < DEPTH);
        wpop  = (wq.size() > 0) && bus.ip_in_ready;
        rpush = bus.ip_out_valid && (rq.size() < DEPTH);
        rpop  = bus.IP_read && !bus.IP_write && (rq.size() > 0);
        wd = bus.mem_rdata;
        rd = bus.ip_out_data;
        @(posedge clk);
        #1;
        last_rpop = rpop;
        last_rval = rpop ? rq[0] : '0;
        if (wpop)  void'(wq.pop_front());
        if (rpop)  void'(rq.pop_front());
        if (wpush) wq.push_back(wd);
        if (rpush) rq.push_back(rd);
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 32'h5, 1'b0, 1'b0, '0);
        #2;
        tests++; if (bus.wcount !== '0) begin fails++; $display("FAIL rst_wcount got %0d want 0", bus.wcount); end
        tests++; if (bus.rcount !== '0) begin fails++; $display("FAIL rst_rcount got %0d want 0", bus.rcount); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", bus.stall); end
        tests++; if (bus.ip_in_valid !== 1'b0) begin fails++; $display("FAIL rst_in_valid got %b want 0", bus.ip_in_valid); end
        tests++; if (bus.ip_out_ready !== 1'b0) begin fails++; $display("FAIL rst_out_ready got %b want 0", bus.ip_out_ready); end
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.ip_out_ready !== 1'b1) begin fails++; $display("FAIL rel_out_ready got %b want 1", bus.ip_out_ready); end
        wq.delete(); rq.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, vals[i], 1'b0, 1'b0, '0);
            #1;
            tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL fill_stall[%0d] got %b want 0", i, bus.stall); end
            tick();
        end
        tests++; if (bus.wcount !== CW'(4)) begin fails++; $display("FAIL fill_wcount got %0d want 4", bus.wcount); end
        set_in(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, '0);
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL full_stall got %b want 1", bus.stall); end
        tick();
        tests++; if (bus.wcount !== CW'(4)) begin fails++; $display("FAIL full_wcount got %0d want 4", bus.wcount); end
        for (int i = 0; i < 4; i++) begin
            // First drain cycle also offers an LWIP that must be refused while full.
            set_in(i == 0, 1'b0, 32'h66, 1'b1, 1'b0, '0);
            #1;
            if (i == 0) begin
                tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL nobypass_stall got %b want 1", bus.stall); end
            end
            tests++;
            if (bus.ip_in_valid !== 1'b1 || bus.ip_in_data !== vals[i]) begin
                fails++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, bus.ip_in_valid, bus.ip_in_data, vals[i]);
            end
            tick();
        end
        tests++; if (bus.ip_in_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b want 0", bus.ip_in_valid); end
    endtask

    task automatic test_swip();
        set_in(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
        #1;
        tests++;
        if (bus.stall !== 1'b1 || bus.mem_wdata !== '0) begin
            fails++; $display("FAIL swip_empty got stall=%b wd=%h want stall=1 wd=0", bus.stall, bus.mem_wdata);
        end
        tick();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hABCD);
        #1;
        tests++; if (bus.mem_wdata !== '0) begin fails++; $display("FAIL idle_wdata got %h want 0", bus.mem_wdata); end
        tick();
        set_in(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
        #1;
        tests++;
        if (bus.stall !== 1'b0 || bus.mem_wdata !== 32'hABCD) begin
            fails++; $display("FAIL swip_data got stall=%b wd=%h want stall=0 wd=abcd", bus.stall, bus.mem_wdata);
        end
        tick();
        tests++; if (bus.rcount !== '0) begin fails++; $display("FAIL swip_rcount got %0d want 0", bus.rcount); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] vals [6];
        logic [DW-1:0] got[$];
        logic [DW-1:0] exp_wd;
        for (int i = 0; i < 6; i++) vals[i] = $urandom;
        for (int k = 0; k < 10; k++) begin
            set_in(1'b0, 1'b1, '0, 1'b0, k < 6, (k < 6) ? vals[k] : '0);
            #1;
            exp_wd = (rq.size() > 0) ? rq[0] : '0;
            tests++; if (bus.mem_wdata !== exp_wd) begin fails++; $display("FAIL wrap_wdata[%0d] got %h want %h", k, bus.mem_wdata, exp_wd); end
            tick();
            if (last_rpop) got.push_back(bus.mem_wdata === bus.mem_wdata ? last_rval : '0);
            tests++; if (bus.rcount > CW'(4)) begin fails++; $display("FAIL wrap_rcount[%0d] got %0d want <=4", k, bus.rcount); end
        end
        tests++;
        if (got.size() != 6) begin
            fails++; $display("FAIL wrap_count got %0d want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++)
                if (got[i] !== vals[i]) begin fails++; $display("FAIL wrap_order[%0d] got %h want %h", i, got[i], vals[i]); end
        end
    endtask

    task automatic test_illegal();
        set_in(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, 32'h77); tick();
        set_in(1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, '0);
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL illegal_stall got %b want 0", bus.stall); end
        tick();
        tests++;
        if (bus.wcount !== CW'(2) || bus.rcount !== CW'(1)) begin
            fails++; $display("FAIL illegal_counts got w=%0d r=%0d want w=2 r=1", bus.wcount, bus.rcount);
        end
    endtask

    task automatic test_random();
        logic w, r;
        logic          e_stall, e_inv, e_outr;
        logic [DW-1:0] e_wd;
        for (int k = 0; k < 300; k++) begin
            w = ($urandom_range(0, 99) < 45);
            r = ($urandom_range(0, 99) < 45);
            set_in(w, r, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            #1;
            e_stall = (w && !r && wq.size() == DEPTH) || (r && !w && rq.size() == 0);
            e_wd    = (r && !w && rq.size() > 0) ? rq[0] : '0;
            e_inv   = (wq.size() > 0);
            e_outr  = (rq.size() < DEPTH);
            tests++;
            if (bus.stall !== e_stall || bus.mem_wdata !== e_wd || bus.ip_in_valid !== e_inv ||
                bus.ip_out_ready !== e_outr || bus.wcount !== CW'(wq.size()) || bus.rcount !== CW'(rq.size()) ||
                (e_inv && bus.ip_in_data !== wq[0])) begin
                fails++;
                $display("FAIL rand[%0d] got st=%b wd=%h iv=%b id=%h or=%b wc=%0d rc=%0d want st=%b wd=%h iv=%b or=%b wc=%0d rc=%0d",
                         k, bus.stall, bus.mem_wdata, bus.ip_in_valid, bus.ip_in_data, bus.ip_out_ready,
                         bus.wcount, bus.rcount, e_stall, e_wd, e_inv, e_outr, wq.size(), rq.size());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #1; rst = 1'b0; #1; rst = 1'b1;
        wq.delete(); rq.delete();
        set_in(1'b1, 1'b0, 32'hB1, 1'b0, 1'b1, 32'hC1); tick();
        set_in(1'b1, 1'b0, 32'hB2, 1'b0, 1'b1, 32'hC2); tick();
        set_in(1'b1, 1'b0, 32'hB3, 1'b0, 1'b0, '0);     tick();
        tests++;
        if (bus.wcount !== CW'(3) || bus.rcount !== CW'(2)) begin
            fails++; $display("FAIL pre_reset got w=%0d r=%0d want w=3 r=2", bus.wcount, bus.rcount);
        end
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hD1);
        #1; rst = 1'b0; #1;
        tests++;
        if (bus.wcount !== '0 || bus.rcount !== '0 || bus.ip_in_valid !== 1'b0 || bus.ip_out_ready !== 1'b0) begin
            fails++; $display("FAIL async_reset got w=%0d r=%0d iv=%b or=%b want 0 0 0 0",
                              bus.wcount, bus.rcount, bus.ip_in_valid, bus.ip_out_ready);
        end
        @(posedge clk); #1;
        tests++; if (bus.wcount !== '0 || bus.rcount !== '0) begin fails++; $display("FAIL held_reset got w=%0d r=%0d want 0 0", bus.wcount, bus.rcount); end
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #2; rst = 1'b1;
        wq.delete(); rq.delete();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_swip();
        test_wrap();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
